d_mux: RTL and testbench
========================

# d_mux

Parameterized, registered 1-to-N demultiplexer. Routes one input word to the output lane chosen by `sel` and drives every other lane to zero; the base configuration (`WIDTH`=1, `NUM_OUT`=2) is the classic two-way `DMux` gate, with `a`=lane 0 and `b`=lane 1. It sits in the logic-primitive library as the building block for wider demux trees, address decoders and register-file write enables.

## Interface
Parameters:
- `WIDTH`, 1, bit width of the data word.
- `NUM_OUT`, 2, number of output lanes, 2..64.
- `SEL_W`, `$clog2(NUM_OUT)`, select width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  `WIDTH`  data word to route.
- `in_valid`  in  1  qualifies `in`/`sel` this cycle.
- `sel`  in  `SEL_W`  destination lane index.
- `out`  out  `NUM_OUT*WIDTH`  lane k occupies bits `[k*WIDTH +: WIDTH]`.
- `out_valid`  out  `NUM_OUT`  one-hot (or zero) lane-valid flags.
- `a`  out  `WIDTH`  alias of lane 0.
- `b`  out  `WIDTH`  alias of lane 1.
- `sel_err`  out  1  sticky out-of-range flag (only with `D_MUX_SEL_CHECK_EN`; tied 0 otherwise).

## Operation
- Lane k next value: `in` if `in_valid` and `sel == k`, else all-zero.
- `out_valid[k]` next value: 1 iff `in_valid` and `sel == k`; at most one bit set.
- Two-way truth table (`in_valid`=1, `WIDTH`=1): (in,sel)=(0,0)→(a,b)=(0,0); (1,0)→(1,0); (0,1)→(0,0); (1,1)→(0,1).
- `in_valid`=0: all lanes and `out_valid` register zero next cycle (no hold).
- `sel >= NUM_OUT` (possible only when `NUM_OUT` is not a power of two): no lane selected, all outputs zero, `out_valid` all zero.
- No backpressure; one word accepted every cycle.

## Timing
- Latency exactly 1 cycle: inputs sampled at edge t appear at outputs after edge t.
- Reset: on any edge with `rst`=1, `out`, `a`, `b`, `out_valid`, `sel_err` all become 0; inputs that cycle are discarded. Reset mid-stream drops the in-flight word.
- First valid output: the cycle after the first edge with `rst`=0 and `in_valid`=1.
- No combinational path from inputs to outputs.

## Configuration
- `D_MUX_SEL_CHECK_EN` defined: `sel_err` sets to 1 on the edge after any cycle with `in_valid`=1 and `sel >= NUM_OUT`; it stays 1 until `rst`. Never sets when `NUM_OUT` is a power of two.
- Not defined: no check logic; `sel_err` is constant 0; routing behaviour identical.

## Structure
- Shared package `d_mux_pkg`: `D_MUX_MAX_OUT` (64) constant, `sel_in_range` function, lane-slice helper.
- One natural sub-module: `d_mux_decoder` (combinational `sel`+`in_valid` → one-hot enable vector); top instantiates it and gates/registers the lanes with a generate loop.
- Elaboration error when `NUM_OUT` < 2 or > 64, or `WIDTH` < 1.

## Test plan
- Truth table, defaults: apply (0,0),(1,0),(0,1),(1,1) with `in_valid`=1 → one cycle later (a,b) = (0,0),(1,0),(0,0),(0,1); `out_valid` = 01,01,10,10.
- Reset: run valid traffic, assert `rst` for one edge with `in`=1,`sel`=0 → all outputs 0 next cycle; output reappears one cycle after `rst` drops.
- Valid gating: `in_valid`=0, `in`=1, `sel`=1 → `b`=0, `out_valid`=00.
- Wide config `WIDTH`=8, `NUM_OUT`=4: stream `in`=0xA5 with `sel`=0,1,2,3 on consecutive cycles → lane k=0xA5 exactly on cycle k+1, others 0x00.
- Out-of-range, `NUM_OUT`=3, macro defined: `sel`=3, `in_valid`=1 → all lanes 0, `sel_err`=1 next cycle and held until `rst`; without macro `sel_err` stays 0.
- Back-to-back alternation `sel`=0/1 every cycle, `in`=1 → a and b toggle out of phase with 1-cycle latency, never both 1.

Source files
------------

// File: rtl/d_mux_pkg.sv
// Shared constants and helpers for the d_mux demultiplexer family.
package d_mux_pkg;

  localparam int unsigned D_MUX_MAX_OUT = 64;

  // True when a select value addresses an existing lane.
  function automatic bit sel_in_range(input int unsigned sel, input int unsigned num_out);
    return sel < num_out;
  endfunction

  // Low bit index of lane k in a packed lane vector.
  function automatic int unsigned lane_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/d_mux_decoder.sv
// Combinational select decoder: sel + in_valid -> one-hot (or zero) lane enables.
module d_mux_decoder #(
  parameter int unsigned NUM_OUT = 2,
  parameter int unsigned SEL_W   = 1
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic [NUM_OUT-1:0] en_c
);

  // Out-of-range selects match no lane and leave the vector zero.
  always_comb begin
    en_c = '0;
    for (int k = 0; k < int'(NUM_OUT); k++) begin
      if (in_valid && (sel == SEL_W'(k))) en_c[k] = 1'b1;
    end
  end

endmodule

// File: rtl/d_mux.sv
// Registered 1-to-N demultiplexer; a/b alias lanes 0/1.
// Optional sticky out-of-range flag enabled by D_MUX_SEL_CHECK_EN.
module d_mux
  import d_mux_pkg::*;
#(
  parameter  int unsigned WIDTH   = 1,
  parameter  int unsigned NUM_OUT = 2,
  localparam int unsigned SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in,
  input  logic                     in_valid,
  input  logic [SEL_W-1:0]         sel,
  output logic [NUM_OUT*WIDTH-1:0] out,
  output logic [NUM_OUT-1:0]       out_valid,
  output logic [WIDTH-1:0]         a,
  output logic [WIDTH-1:0]         b,
  output logic                     sel_err
);

  if (NUM_OUT < 2 || NUM_OUT > D_MUX_MAX_OUT) begin : g_bad_num_out
    $error("d_mux: NUM_OUT must be in 2..%0d", D_MUX_MAX_OUT);
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("d_mux: WIDTH must be at least 1");
  end

  logic [NUM_OUT-1:0]       en_c;
  logic [NUM_OUT*WIDTH-1:0] out_d_c;

  d_mux_decoder #(
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W)
  ) u_decoder (
    .sel      (sel),
    .in_valid (in_valid),
    .en_c     (en_c)
  );

  // Each lane sees the input word only when its enable is set.
  for (genvar k = 0; k < int'(NUM_OUT); k++) begin : g_lane
    assign out_d_c[lane_lo(k, WIDTH) +: WIDTH] = {WIDTH{en_c[k]}} & in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= '0;
    end else begin
      out       <= out_d_c;
      out_valid <= en_c;
    end
  end

  assign a = out[lane_lo(0, WIDTH) +: WIDTH];
  assign b = out[lane_lo(1, WIDTH) +: WIDTH];

`ifdef D_MUX_SEL_CHECK_EN
  // Sticky until reset; unreachable when NUM_OUT is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (in_valid && !sel_in_range(32'(sel), NUM_OUT)) begin
      sel_err <= 1'b1;
    end
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_d_mux.sv
// Scoreboard bench for d_mux: default 2-way, 8-bit 4-way and 1-bit 3-way instances.
module tb_d_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, vld;
  logic       in0, sel0;
  logic [7:0] in1;
  logic [1:0] sel1;
  logic       in2;
  logic [1:0] sel2;

  logic [1:0]  out0, ov0;
  logic        a0, b0, err0;
  logic [31:0] out1;
  logic [3:0]  ov1;
  logic [7:0]  a1, b1;
  logic        err1;
  logic [2:0]  out2, ov2;
  logic        a2, b2, err2;

  d_mux u_dut0 (
    .clk(clk), .rst(rst), .in(in0), .in_valid(vld), .sel(sel0),
    .out(out0), .out_valid(ov0), .a(a0), .b(b0), .sel_err(err0)
  );

  d_mux #(.WIDTH(8), .NUM_OUT(4)) u_dut1 (
    .clk(clk), .rst(rst), .in(in1), .in_valid(vld), .sel(sel1),
    .out(out1), .out_valid(ov1), .a(a1), .b(b1), .sel_err(err1)
  );

  d_mux #(.WIDTH(1), .NUM_OUT(3)) u_dut2 (
    .clk(clk), .rst(rst), .in(in2), .in_valid(vld), .sel(sel2),
    .out(out2), .out_valid(ov2), .a(a2), .b(b2), .sel_err(err2)
  );

  typedef struct {
    string       tag;
    logic [1:0]  o0, v0;
    logic [31:0] o1;
    logic [3:0]  v1;
    logic [2:0]  o2, v2;
    logic        e2;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_miss = 0;
  logic err_m  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the model result, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic i0, input logic s0,
                      input logic [7:0] i1, input logic [1:0] s1,
                      input logic i2, input logic [1:0] s2);
    exp_t e, g;
    rst = r; vld = v;
    in0 = i0; sel0 = s0; in1 = i1; sel1 = s1; in2 = i2; sel2 = s2;
    e.tag = tag;
    e.o0 = '0; e.v0 = '0; e.o1 = '0; e.v1 = '0; e.o2 = '0; e.v2 = '0;
    if (r) begin
      err_m = 1'b0;
    end else if (v) begin
      for (int k = 0; k < 2; k++) if (int'(s0) == k) begin e.o0[k] = i0; e.v0[k] = 1'b1; end
      for (int k = 0; k < 4; k++) if (int'(s1) == k) begin e.o1[k*8 +: 8] = i1; e.v1[k] = 1'b1; end
      for (int k = 0; k < 3; k++) if (int'(s2) == k) begin e.o2[k] = i2; e.v2[k] = 1'b1; end
`ifdef D_MUX_SEL_CHECK_EN
      if (int'(s2) >= 3) err_m = 1'b1;
`endif
    end
    e.e2 = err_m;
    sb.push_back(e);
    n_vec++;
    @(posedge clk);
    #1;
    chk({tag, ":sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    g = sb.pop_front();
    chk({g.tag, ":out0"}, 32'(out0), 32'(g.o0));
    chk({g.tag, ":ov0"},  32'(ov0),  32'(g.v0));
    chk({g.tag, ":a0"},   32'(a0),   32'(g.o0[0]));
    chk({g.tag, ":b0"},   32'(b0),   32'(g.o0[1]));
    chk({g.tag, ":err0"}, 32'(err0), 32'd0);
    chk({g.tag, ":out1"}, out1,      g.o1);
    chk({g.tag, ":ov1"},  32'(ov1),  32'(g.v1));
    chk({g.tag, ":a1"},   32'(a1),   32'(g.o1[7:0]));
    chk({g.tag, ":b1"},   32'(b1),   32'(g.o1[15:8]));
    chk({g.tag, ":err1"}, 32'(err1), 32'd0);
    chk({g.tag, ":out2"}, 32'(out2), 32'(g.o2));
    chk({g.tag, ":ov2"},  32'(ov2),  32'(g.v2));
    chk({g.tag, ":a2"},   32'(a2),   32'(g.o2[0]));
    chk({g.tag, ":b2"},   32'(b2),   32'(g.o2[1]));
    chk({g.tag, ":err2"}, 32'(err2), 32'(g.e2));
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0;
    in0 = 1'b0; sel0 = 1'b0; in1 = '0; sel1 = '0; in2 = 1'b0; sel2 = '0;

    // Reset with live inputs: discarded.
    step("rst0", 1, 1, 1, 0, 8'hFF, 2'd0, 1, 2'd0);
    step("rst1", 1, 0, 0, 0, 8'h00, 2'd0, 0, 2'd0);

    // Two-way truth table.
    step("tt00", 0, 1, 0, 0, 8'h00, 2'd0, 0, 2'd0);
    step("tt10", 0, 1, 1, 0, 8'h11, 2'd0, 1, 2'd0);
    step("tt01", 0, 1, 0, 1, 8'h00, 2'd1, 0, 2'd1);
    step("tt11", 0, 1, 1, 1, 8'h22, 2'd1, 1, 2'd1);

    // Valid gating: no hold of the previous word.
    step("gate", 0, 0, 1, 1, 8'hFF, 2'd1, 1, 2'd1);

    // Wide stream of 0xA5 across all four lanes.
    step("wide0", 0, 1, 1, 0, 8'hA5, 2'd0, 1, 2'd0);
    step("wide1", 0, 1, 1, 1, 8'hA5, 2'd1, 1, 2'd1);
    step("wide2", 0, 1, 1, 0, 8'hA5, 2'd2, 1, 2'd2);
    step("wide3", 0, 1, 1, 1, 8'hA5, 2'd3, 1, 2'd2);

    // Reset mid-stream drops the word; output returns one cycle after release.
    step("mid_rst", 1, 1, 1, 0, 8'h5A, 2'd0, 1, 2'd0);
    step("post_rst", 0, 1, 1, 0, 8'h5A, 2'd0, 1, 2'd0);

    // Out-of-range select on the 3-lane instance; flag is sticky.
    step("oor", 0, 1, 1, 1, 8'h3C, 2'd3, 1, 2'd3);
    step("oor_hold0", 0, 1, 1, 0, 8'h3C, 2'd2, 1, 2'd1);
    step("oor_hold1", 0, 0, 0, 0, 8'h00, 2'd0, 0, 2'd0);
    step("oor_clr", 1, 0, 0, 0, 8'h00, 2'd0, 0, 2'd0);
    step("oor_after", 0, 1, 1, 0, 8'h01, 2'd0, 1, 2'd0);

    // Back-to-back alternation between lanes 0 and 1.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("alt%0d", i), 0, 1, 1, 1'(i & 1), 8'h80 | 8'(i), 2'(i & 1), 1, 2'(i & 1));
    end

    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 9) == 0), 1'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom), 2'($urandom),
           1'($urandom), 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
